// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - FRiscV shared types: sequencer states and base opcodes
//
// Purpose: state encoding for the multi-cycle sequencer plus the opcode
// constants the sequencer needs to classify the instruction register.
// No ports (package).

package friscv_pkg;

   typedef enum logic [2:0] {
      FETCH      = 3'd0,
      FETCH_WAIT = 3'd1,
      DECODE     = 3'd2,
      EXECUTE    = 3'd3,
      MEM        = 3'd4,
      MEM_WAIT   = 3'd5,
      WRITEBACK  = 3'd6,
      TRAP       = 3'd7
   } seq_state_t;

   localparam logic [6:0] OP_REG       = 7'b0110011;
   localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
   localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JUMP      = 7'b1101111;

   function automatic logic is_legal_op(input logic [6:0] op);
      case (op)
         OP_REG, OP_IMM_ARITH, OP_IMM_LOAD,
         OP_STORE, OP_BRANCH, OP_JUMP: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wdog.sv
// rtl/mem_wdog.sv - memory handshake watchdog counter
//
// Purpose: counts cycles spent waiting for a memory event and flags the
// last permitted wait cycle. LIMIT = 0 disables expiry.
// Ports:
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   clear_i    return the count to zero
//   count_i    one more cycle waited without the awaited event
//   expired_o  this is the LIMIT-th waiting cycle (no further waits allowed)

module mem_wdog #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam int unsigned LAST = (LIMIT == 0) ? 0 : LIMIT - 1;

   logic [W-1:0] cnt_q, cnt_d;

   // The count equals the number of waits already elapsed, so the cycle on
   // which it reads LIMIT-1 is the LIMIT-th wait: the caller traps unless the
   // awaited event shows up in that same cycle.
   assign expired_o = (LIMIT != 0) && (cnt_q == W'(LAST));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i && (LIMIT != 0) && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FRiscV multi-cycle datapath sequencer
//
// Purpose: steps FETCH..WRITEBACK over one shared instr/data memory port,
// issuing datapath enables and memory handshakes; traps on an illegal
// opcode or a memory timeout. Optional perf counters: FRISCV_PERF_CNT_EN.
// Ports:
//   clk_in, rst_n_in          clock / async active-low reset
//   op_code_in, zero_in       IR opcode field, ALU zero flag
//   halt_in                   hold in FETCH without requesting
//   mem_gnt_in, mem_rvalid_in memory accept / read data valid
//   mem_req_out, mem_we_out, mem_addr_sel_out   memory request controls
//   ir_write_out, pc_write_out, pc_src_out, reg_write_out   datapath enables
//   instr_retired_out         one pulse per completed instruction
//   trap_out                  sticky trap indication
//   state_out                 current state (debug)
//   cycle_cnt_out, instret_cnt_out   perf counters (FRISCV_PERF_CNT_EN)

import friscv_pkg::*;

module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [6:0]       op_code_in,
   input  logic             zero_in,
   input  logic             halt_in,
   input  logic             mem_gnt_in,
   input  logic             mem_rvalid_in,
   output logic             mem_req_out,
   output logic             mem_we_out,
   output logic             mem_addr_sel_out,
   output logic             ir_write_out,
   output logic             pc_write_out,
   output logic             pc_src_out,
   output logic             reg_write_out,
   output logic             instr_retired_out,
   output logic             trap_out,
`ifdef FRISCV_PERF_CNT_EN
   output logic [CNT_W-1:0] cycle_cnt_out,
   output logic [CNT_W-1:0] instret_cnt_out,
`endif
   output logic [2:0]       state_out
);

   seq_state_t state_q, state_d;
   logic       req, we, addr_sel, ir_write, pc_write, pc_src, reg_write, retire;
   logic       wd_count, wd_expired;

   // Counts only while stalled in a request/wait state; every other cycle
   // (state change, halted FETCH, non-memory states) clears it, which gives
   // the clear-on-entry behaviour for free.
   mem_wdog #(.LIMIT(MEM_TIMEOUT)) u_wdog (
      .clk_i     (clk_in),
      .rst_n_i   (rst_n_in),
      .clear_i   (!wd_count),
      .count_i   (wd_count),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req       = 1'b0;
      we        = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      wd_count  = 1'b0;
      case (state_q)
         FETCH: begin
            if (!halt_in) begin
               req = 1'b1;
               if (mem_gnt_in)      state_d = FETCH_WAIT;
               else if (wd_expired) state_d = TRAP;
               else                 wd_count = 1'b1;
            end
         end
         FETCH_WAIT: begin
            if (mem_rvalid_in) begin
               ir_write = 1'b1;
               state_d  = DECODE;
            end else if (wd_expired) begin
               state_d = TRAP;
            end else begin
               wd_count = 1'b1;
            end
         end
         DECODE: begin
            state_d = is_legal_op(op_code_in) ? EXECUTE : TRAP;
         end
         EXECUTE: begin
            case (op_code_in)
               OP_BRANCH: begin
                  pc_write = 1'b1;
                  pc_src   = zero_in;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end
               OP_IMM_LOAD, OP_STORE: state_d = MEM;
               default:               state_d = WRITEBACK;
            endcase
         end
         MEM: begin
            req      = 1'b1;
            addr_sel = 1'b1;
            we       = (op_code_in == OP_STORE);
            if (mem_gnt_in) begin
               if (op_code_in == OP_STORE) begin
                  // A store has nothing to write back, so it retires on grant.
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end else begin
                  state_d = MEM_WAIT;
               end
            end else if (wd_expired) begin
               state_d = TRAP;
            end else begin
               wd_count = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_rvalid_in)   state_d = WRITEBACK;
            else if (wd_expired) state_d = TRAP;
            else                 wd_count = 1'b1;
         end
         WRITEBACK: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            pc_src    = (op_code_in == OP_JUMP);
            retire    = 1'b1;
            state_d   = FETCH;
         end
         default: begin
            state_d = TRAP;
         end
      endcase
   end

   // Reset also forces the Moore outputs low, otherwise FETCH would raise a
   // request while reset is still held.
   assign mem_req_out       = rst_n_in & req;
   assign mem_we_out        = rst_n_in & we;
   assign mem_addr_sel_out  = rst_n_in & addr_sel;
   assign ir_write_out      = rst_n_in & ir_write;
   assign pc_write_out      = rst_n_in & pc_write;
   assign pc_src_out        = rst_n_in & pc_src;
   assign reg_write_out     = rst_n_in & reg_write;
   assign instr_retired_out = rst_n_in & retire;
   assign trap_out          = rst_n_in & (state_q == TRAP);
   assign state_out         = state_q;

`ifdef FRISCV_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         if (state_q != TRAP) cycle_cnt_q <= cycle_cnt_q + 1'b1;
         if (retire)          instret_cnt_q <= instret_cnt_q + 1'b1;
      end
   end

   assign cycle_cnt_out   = cycle_cnt_q;
   assign instret_cnt_out = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer

module tb_multicycle_sequencer;

   localparam int unsigned TO = 4;

   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;

   // Expected-output flag bits: req we addr_sel ir_write pc_write pc_src reg_write retired trap
   localparam logic [8:0] NONE   = 9'b000000000;
   localparam logic [8:0] F_REQ  = 9'b100000000;
   localparam logic [8:0] F_WE   = 9'b010000000;
   localparam logic [8:0] F_AS   = 9'b001000000;
   localparam logic [8:0] F_IR   = 9'b000100000;
   localparam logic [8:0] F_PCW  = 9'b000010000;
   localparam logic [8:0] F_SRC  = 9'b000001000;
   localparam logic [8:0] F_RW   = 9'b000000100;
   localparam logic [8:0] F_RET  = 9'b000000010;
   localparam logic [8:0] F_TRAP = 9'b000000001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       zero, halt, gnt, rv;
   logic       mem_req, mem_we, mem_as, ir_w, pc_w, pc_s, reg_w, retired, trap;
   logic [2:0] state;
`ifdef FRISCV_PERF_CNT_EN
   logic [15:0] cyc_cnt, ins_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .op_code_in        (op),
      .zero_in           (zero),
      .halt_in           (halt),
      .mem_gnt_in        (gnt),
      .mem_rvalid_in     (rv),
      .mem_req_out       (mem_req),
      .mem_we_out        (mem_we),
      .mem_addr_sel_out  (mem_as),
      .ir_write_out      (ir_w),
      .pc_write_out      (pc_w),
      .pc_src_out        (pc_s),
      .reg_write_out     (reg_w),
      .instr_retired_out (retired),
      .trap_out          (trap),
`ifdef FRISCV_PERF_CNT_EN
      .cycle_cnt_out     (cyc_cnt),
      .instret_cnt_out   (ins_cnt),
`endif
      .state_out         (state)
   );

   function automatic logic [11:0] obs();
      return {state, mem_req, mem_we, mem_as, ir_w, pc_w, pc_s, reg_w, retired, trap};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      halt  = 1'b1;
      gnt   = 1'b0;
      rv    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         {gnt, rv, zero, halt} = 4'($urandom);
         op = 7'($urandom);
         @(negedge clk);
         checks++;
         if (obs() !== 12'd0) begin
            errors++;
            $display("FAIL reset[%0d]: got %b want %b", i, obs(), 12'd0);
         end
`ifdef FRISCV_PERF_CNT_EN
         checks++;
         if (cyc_cnt !== 16'd0 || ins_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf: got cyc=%0d ins=%0d want 0 0", cyc_cnt, ins_cnt);
         end
`endif
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      halt = 1'b1;
      gnt  = 1'b0;
      rv   = 1'b0;
   endtask

   // inputs per row: {gnt, rvalid, zero, halt}
   task automatic test_add();
      logic [3:0]  vin[6];
      logic [11:0] vex[6];
      vin = '{4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      vex = '{{3'd0, F_REQ}, {3'd1, F_IR}, {3'd2, NONE}, {3'd3, NONE},
              {3'd6, F_PCW | F_RW | F_RET}, {3'd0, NONE}};
      op = ADD;
      for (int i = 0; i < 6; i++) begin
         {gnt, rv, zero, halt} = vin[i];
         @(negedge clk);
         checks++;
         if (obs() !== vex[i]) begin
            errors++;
            $display("FAIL add[%0d]: got %b want %b", i, obs(), vex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      logic [3:0]  vin[10];
      logic [11:0] vex[10];
      vin = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0001,
              4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
      vex = '{{3'd0, F_REQ}, {3'd1, F_IR}, {3'd2, NONE}, {3'd3, F_PCW | F_SRC | F_RET}, {3'd0, NONE},
              {3'd0, F_REQ}, {3'd1, F_IR}, {3'd2, NONE}, {3'd3, F_PCW | F_RET}, {3'd0, NONE}};
      op = BEQ;
      for (int i = 0; i < 10; i++) begin
         {gnt, rv, zero, halt} = vin[i];
         @(negedge clk);
         checks++;
         if (obs() !== vex[i]) begin
            errors++;
            $display("FAIL branch[%0d]: got %b want %b", i, obs(), vex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_delayed_gnt();
      logic [3:0]  vin[12];
      logic [11:0] vex[12];
      vin = '{4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
              4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      vex = '{{3'd0, F_REQ}, {3'd1, F_IR}, {3'd2, NONE}, {3'd3, NONE},
              {3'd4, F_REQ | F_AS}, {3'd4, F_REQ | F_AS}, {3'd4, F_REQ | F_AS}, {3'd4, F_REQ | F_AS},
              {3'd5, NONE}, {3'd5, NONE}, {3'd6, F_PCW | F_RW | F_RET}, {3'd0, NONE}};
      op = LW;
      for (int i = 0; i < 12; i++) begin
         {gnt, rv, zero, halt} = vin[i];
         @(negedge clk);
         checks++;
         if (obs() !== vex[i]) begin
            errors++;
            $display("FAIL load[%0d]: got %b want %b", i, obs(), vex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal_trap();
      logic [3:0]  vin[8];
      logic [11:0] vex[8];
      vin = '{4'b1000, 4'b0100, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b1010, 4'b0001};
      vex = '{{3'd0, F_REQ}, {3'd1, F_IR}, {3'd2, NONE}, {3'd7, F_TRAP},
              {3'd7, F_TRAP}, {3'd7, F_TRAP}, {3'd7, F_TRAP}, {3'd7, F_TRAP}};
      op = 7'h7F;
      for (int i = 0; i < 8; i++) begin
         {gnt, rv, zero, halt} = vin[i];
         @(negedge clk);
         checks++;
         if (obs() !== vex[i]) begin
            errors++;
            $display("FAIL illegal[%0d]: got %b want %b", i, obs(), vex[i]);
         end
         @(posedge clk); #1;
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (obs() !== {3'd0, NONE}) begin
         errors++;
         $display("FAIL illegal_after_reset: got %b want %b", obs(), {3'd0, NONE});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      logic [3:0]  va[6];
      logic [11:0] xa[6];
      logic [3:0]  vb[9];
      logic [11:0] xb[9];
      va = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      xa = '{{3'd0, F_REQ}, {3'd1, NONE}, {3'd1, NONE}, {3'd1, NONE}, {3'd1, NONE}, {3'd7, F_TRAP}};
      vb = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      xb = '{{3'd0, F_REQ}, {3'd1, NONE}, {3'd1, NONE}, {3'd1, NONE}, {3'd1, F_IR},
             {3'd2, NONE}, {3'd3, NONE}, {3'd6, F_PCW | F_RW | F_RET}, {3'd0, NONE}};
      op = ADDI;
      for (int i = 0; i < 6; i++) begin
         {gnt, rv, zero, halt} = va[i];
         @(negedge clk);
         checks++;
         if (obs() !== xa[i]) begin
            errors++;
            $display("FAIL timeout_expire[%0d]: got %b want %b", i, obs(), xa[i]);
         end
         @(posedge clk); #1;
      end
      do_reset();
      for (int i = 0; i < 9; i++) begin
         {gnt, rv, zero, halt} = vb[i];
         @(negedge clk);
         checks++;
         if (obs() !== xb[i]) begin
            errors++;
            $display("FAIL timeout_limit_event[%0d]: got %b want %b", i, obs(), xb[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_op();
      logic [3:0]  vin[6];
      logic [11:0] vex[6];
      vin = '{4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
      vex = '{{3'd0, F_REQ}, {3'd1, F_IR}, {3'd2, NONE}, {3'd3, NONE}, {3'd4, F_REQ | F_AS}, {3'd5, NONE}};
      op = LW;
      for (int i = 0; i < 6; i++) begin
         {gnt, rv, zero, halt} = vin[i];
         @(negedge clk);
         checks++;
         if (obs() !== vex[i]) begin
            errors++;
            $display("FAIL midreset_setup[%0d]: got %b want %b", i, obs(), vex[i]);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      {gnt, rv, zero, halt} = 4'b0100;
      @(negedge clk);
      checks++;
      if (obs() !== 12'd0) begin
         errors++;
         $display("FAIL midreset_hold: got %b want %b", obs(), 12'd0);
      end
`ifdef FRISCV_PERF_CNT_EN
      checks++;
      if (cyc_cnt !== 16'd0 || ins_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midreset_perf: got cyc=%0d ins=%0d want 0 0", cyc_cnt, ins_cnt);
      end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rv = (i == 0);
         @(negedge clk);
         checks++;
         if (obs() !== {3'd0, F_REQ}) begin
            errors++;
            $display("FAIL midreset_stale_rvalid[%0d]: got %b want %b", i, obs(), {3'd0, F_REQ});
         end
         @(posedge clk); #1;
      end
      halt = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== {3'd0, NONE}) begin
         errors++;
         $display("FAIL midreset_halt: got %b want %b", obs(), {3'd0, NONE});
      end
      @(posedge clk); #1;
   endtask

   typedef struct packed {
      logic [3:0]  vin;
      logic [6:0]  op;
      logic [11:0] vex;
   } row_t;

   row_t q[$];

   function automatic void push(input logic [3:0] vin, input logic [6:0] o, input logic [11:0] vex);
      row_t r;
      r.vin = vin;
      r.op  = o;
      r.vex = vex;
      q.push_back(r);
   endfunction

   // Reference: each instruction expands into the phase sequence its class
   // goes through, with a random number of stall cycles before every memory
   // event (kept below the timeout) and junk on the inputs that must be ignored.
   task automatic test_random_stream();
      logic [6:0] ops[6];
      logic [6:0] o;
      logic       z;
      int         nh, g1, r1, g2, r2, retires;
      ops = '{ADD, ADDI, LW, SW, BEQ, JAL};
      q.delete();
      retires = 0;
      for (int n = 0; n < 40; n++) begin
         o  = ops[$urandom_range(0, 5)];
         z  = 1'($urandom);
         nh = $urandom_range(0, 2);
         g1 = $urandom_range(0, TO - 1);
         r1 = $urandom_range(0, TO - 1);
         g2 = $urandom_range(0, TO - 1);
         r2 = $urandom_range(0, TO - 1);
         for (int k = 0; k < nh; k++) push({2'($urandom), z, 1'b1}, o, {3'd0, NONE});
         for (int k = 0; k < g1; k++) push({1'b0, 1'($urandom), z, 1'b0}, o, {3'd0, F_REQ});
         push({1'b1, 1'($urandom), z, 1'b0}, o, {3'd0, F_REQ});
         for (int k = 0; k < r1; k++) push({1'($urandom), 1'b0, z, 1'($urandom)}, o, {3'd1, NONE});
         push({1'($urandom), 1'b1, z, 1'($urandom)}, o, {3'd1, F_IR});
         push({2'($urandom), z, 1'($urandom)}, o, {3'd2, NONE});
         if (o == BEQ) begin
            push({2'($urandom), z, 1'($urandom)}, o, {3'd3, F_PCW | (z ? F_SRC : NONE) | F_RET});
            retires++;
         end else if (o == LW || o == SW) begin
            push({2'($urandom), z, 1'($urandom)}, o, {3'd3, NONE});
            for (int k = 0; k < g2; k++)
               push({1'b0, 1'($urandom), z, 1'($urandom)}, o, {3'd4, F_REQ | F_AS | (o == SW ? F_WE : NONE)});
            if (o == SW) begin
               push({1'b1, 1'($urandom), z, 1'($urandom)}, o, {3'd4, F_REQ | F_AS | F_WE | F_PCW | F_RET});
               retires++;
            end else begin
               push({1'b1, 1'($urandom), z, 1'($urandom)}, o, {3'd4, F_REQ | F_AS});
               for (int k = 0; k < r2; k++) push({1'($urandom), 1'b0, z, 1'($urandom)}, o, {3'd5, NONE});
               push({1'($urandom), 1'b1, z, 1'($urandom)}, o, {3'd5, NONE});
               push({2'($urandom), z, 1'($urandom)}, o, {3'd6, F_PCW | F_RW | F_RET});
               retires++;
            end
         end else begin
            push({2'($urandom), z, 1'($urandom)}, o, {3'd3, NONE});
            push({2'($urandom), z, 1'($urandom)}, o, {3'd6, F_PCW | (o == JAL ? F_SRC : NONE) | F_RW | F_RET});
            retires++;
         end
      end
      push(4'b0001, ADD, {3'd0, NONE});
      do_reset();
      foreach (q[i]) begin
         {gnt, rv, zero, halt} = q[i].vin;
         op = q[i].op;
         @(negedge clk);
         checks++;
         if (obs() !== q[i].vex) begin
            errors++;
            $display("FAIL random[%0d] op=%b: got %b want %b", i, q[i].op, obs(), q[i].vex);
         end
`ifdef FRISCV_PERF_CNT_EN
         if (i == q.size() - 1) begin
            checks++;
            if (cyc_cnt !== 16'(i) || ins_cnt !== 16'(retires)) begin
               errors++;
               $display("FAIL random_perf: got cyc=%0d ins=%0d want %0d %0d", cyc_cnt, ins_cnt, i, retires);
            end
         end
`endif
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      op    = ADD;
      zero  = 1'b0;
      halt  = 1'b1;
      gnt   = 1'b0;
      rv    = 1'b0;
      test_reset();
      test_add();
      test_branch();
      test_load_delayed_gnt();
      test_illegal_trap();
      test_timeout();
      test_reset_mid_op();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

endmodule
